// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: reads operands from an 8x32 register file, drives the ALU
// and writes the captured result back; also supports immediate loads.
module alu_exec_ctrl #(
    parameter int NREG  = 8,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_load,
    input  logic [3:0]              in_op,
    input  logic [$clog2(NREG)-1:0] in_rd,
    input  logic [$clog2(NREG)-1:0] in_rs,
    input  logic [$clog2(NREG)-1:0] in_rt,
    input  logic [WIDTH-1:0]        in_imm,
    output logic [WIDTH-1:0]        alu_x,
    output logic [WIDTH-1:0]        alu_y,
    output logic [3:0]              alu_op,
    input  logic [WIDTH-1:0]        alu_z,
    input  logic                    alu_equal,
    input  logic                    alu_overflow,
    output logic                    done,
    output logic [2:0]              flags,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [WIDTH-1:0]        dbg_data
);

    localparam int AW = $clog2(NREG);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        EXEC,
        WB
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] imm_q;
    logic [3:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    rs_q;
    logic [AW-1:0]    rt_q;

    // r0 is never written and always reads as zero
    function automatic logic [WIDTH-1:0] rd_reg(input logic [AW-1:0] a);
        return (a == '0) ? '0 : regs[a];
    endfunction

    assign dbg_data = rd_reg(dbg_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            done     <= 1'b0;
            alu_x    <= '0;
            alu_y    <= '0;
            alu_op   <= '0;
            flags    <= '0;
            result_q <= '0;
            imm_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        imm_q    <= in_imm;
                        op_q     <= in_op;
                        rd_q     <= in_rd;
                        rs_q     <= in_rs;
                        rt_q     <= in_rt;
                        in_ready <= 1'b0;
                        if (in_load) begin
                            state <= LOAD;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                LOAD: begin
                    if (rd_q != '0) regs[rd_q] <= imm_q;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                READ: begin
                    alu_x  <= rd_reg(rs_q);
                    alu_y  <= rd_reg(rt_q);
                    alu_op <= op_q;
                    state  <= EXEC;
                end
                EXEC: begin
                    result_q <= alu_z;
                    flags    <= {alu_equal, alu_overflow, (alu_z == '0)};
                    done     <= 1'b1;
                    state    <= WB;
                end
                WB: begin
                    if (rd_q != '0) regs[rd_q] <= result_q;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
